// File: rtl/ata_pkg.sv
// ata_pkg: task-file register map, command opcodes, status bit positions and
// the transfer FSM state type shared by the ATA PIO target.
package ata_pkg;

   // CS0 command-block register addresses
   localparam logic [2:0] A_DATA   = 3'd0;
   localparam logic [2:0] A_ERR    = 3'd1;  // ERROR (rd) / FEATURES (wr)
   localparam logic [2:0] A_SECCNT = 3'd2;
   localparam logic [2:0] A_LBA0   = 3'd3;
   localparam logic [2:0] A_LBA1   = 3'd4;
   localparam logic [2:0] A_LBA2   = 3'd5;
   localparam logic [2:0] A_DEV    = 3'd6;
   localparam logic [2:0] A_CMD    = 3'd7;  // STATUS (rd) / COMMAND (wr)
   // CS1 control-block register address
   localparam logic [2:0] A_ALT    = 3'd6;  // ALTSTATUS (rd) / DEVCTL (wr)

   localparam logic [7:0] CMD_READ  = 8'h20;
   localparam logic [7:0] CMD_WRITE = 8'h30;

   localparam logic [7:0] ERR_ABRT    = 8'h04;
   localparam logic [7:0] ERR_DIAG_OK = 8'h01;

   // STATUS bit positions
   localparam int ST_BSY  = 7;
   localparam int ST_DRDY = 6;
   localparam int ST_DSC  = 4;
   localparam int ST_DRQ  = 3;
   localparam int ST_ERR  = 0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DRQ_RD,
      S_DRQ_WR,
      S_FLUSH
   } ata_state_t;

endpackage

// File: rtl/ata_sector_buf.sv
// ata_sector_buf: one-sector, single-port 16-bit buffer. The owner (bus or
// backend) is chosen by the target FSM; read data lags the address by a cycle.
module ata_sector_buf #(
   parameter int WPS = 256,
   parameter int AW  = $clog2(WPS)
) (
   input  logic          CLKCPU,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [15:0]   wdata,
   output logic [15:0]   rdata
);

   logic [15:0] mem [WPS];

   // read-first single port
   always_ff @(posedge CLKCPU) begin
      if (we)
         mem[addr] <= wdata;
      rdata <= mem[addr];
   end

endmodule

// File: rtl/ata_device_target.sv
// ata_device_target: device side of an ATA PIO IDE bus. Synchronises the host
// strobes, holds the task file, runs BSY/DRQ sector protocol for READ SECTORS
// (0x20) and WRITE SECTORS (0x30) against a block backend.
// Optional: define ATA_INTRQ_EN to drive IDE_INTRQ; otherwise it is tied 0.
module ata_device_target
   import ata_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int WPS         = 256
) (
   input  logic        CLKCPU,
   input  logic        RESET,
   input  logic [1:0]  IDE_CS_n,
   input  logic [2:0]  IDE_A,
   input  logic        IDE_IOR_n,
   input  logic        IDE_IOW_n,
   input  logic [15:0] IDE_D_IN,
   output logic [15:0] IDE_D_OUT,
   output logic        IDE_D_OE,
   output logic        IDE_INTRQ,
   output logic        BE_CMD_VALID,
   input  logic        BE_CMD_READY,
   output logic        BE_CMD_WRITE,
   output logic [27:0] BE_LBA,
   input  logic [15:0] BE_FILL_DATA,
   input  logic        BE_FILL_VALID,
   output logic [15:0] BE_DRAIN_DATA,
   output logic        BE_DRAIN_VALID,
   input  logic        BE_DRAIN_READY,
   input  logic        BE_DONE,
   input  logic        BE_ERR
);

   localparam int AW = $clog2(WPS);

   logic [SYNC_STAGES-1:0] ior_sync, iow_sync;
   logic       ior_q, iow_q, ior_s, iow_s;
   logic       wr_ev, rd_ev, cs0, cs1, wr_cs0, busy, last, abort;
   logic       srst, nien, err, irq_evt;
   logic       be_cmd_valid, be_cmd_write, drain_prm, drain_done;
   logic       buf_we;
   logic [15:0] buf_wdata, buf_rdata, rd_mux;
   logic [7:0]  status, error_reg;
   logic [3:0]  dev_hi;
   logic [8:0]  seccnt;
   logic [27:0] lba, be_lba;
   logic [AW-1:0] ptr;
   ata_state_t state;

   // strobe synchronisers; the extra flop gives the rising-edge detect
   always_ff @(posedge CLKCPU) begin
      if (RESET) begin
         ior_sync <= '1;
         iow_sync <= '1;
         ior_q    <= 1'b1;
         iow_q    <= 1'b1;
      end else begin
         ior_sync <= {ior_sync[SYNC_STAGES-2:0], IDE_IOR_n};
         iow_sync <= {iow_sync[SYNC_STAGES-2:0], IDE_IOW_n};
         ior_q    <= ior_s;
         iow_q    <= iow_s;
      end
   end

   assign ior_s  = ior_sync[SYNC_STAGES-1];
   assign iow_s  = iow_sync[SYNC_STAGES-1];
   assign cs0    = (IDE_CS_n == 2'b10);
   assign cs1    = (IDE_CS_n == 2'b01);
   assign wr_ev  = iow_s & ~iow_q;
   assign rd_ev  = ior_s & ~ior_q & ~wr_ev;   // a colliding write wins
   assign wr_cs0 = wr_ev & cs0;
   assign busy   = srst | (state == S_FETCH) | (state == S_FLUSH);
   assign last   = (ptr == AW'(WPS - 1));
   assign abort  = BE_ERR |
                   (wr_cs0 & ~busy & (IDE_A == A_CMD) &
                    (~dev_hi[2] | ((IDE_D_IN[7:0] != CMD_READ) & (IDE_D_IN[7:0] != CMD_WRITE))));

   // DRDY/DSC are reported together; both drop only while SRST is held
   always_comb begin
      status          = 8'h00;
      status[ST_BSY]  = busy;
      status[ST_DRDY] = ~srst;
      status[ST_DSC]  = ~srst;
      status[ST_DRQ]  = (state == S_DRQ_RD) | (state == S_DRQ_WR);
      status[ST_ERR]  = err;
   end

   assign buf_we    = ((state == S_FETCH) & BE_FILL_VALID) |
                      ((state == S_DRQ_WR) & wr_cs0 & ~abort & (IDE_A == A_DATA));
   assign buf_wdata = (state == S_FETCH) ? BE_FILL_DATA : IDE_D_IN;

   ata_sector_buf #(.WPS(WPS), .AW(AW)) u_buf (
      .CLKCPU (CLKCPU),
      .we     (buf_we),
      .addr   (ptr),
      .wdata  (buf_wdata),
      .rdata  (buf_rdata)
   );

   assign BE_CMD_VALID   = be_cmd_valid;
   assign BE_CMD_WRITE   = be_cmd_write;
   assign BE_LBA         = be_lba;
   assign BE_DRAIN_DATA  = buf_rdata;
   assign BE_DRAIN_VALID = (state == S_FLUSH) & drain_prm & ~drain_done;

   // device control: only a hard reset clears it, so SRST can be released
   always_ff @(posedge CLKCPU) begin
      if (RESET) begin
         srst <= 1'b0;
         nien <= 1'b0;
      end else if (wr_ev && cs1 && IDE_A == A_ALT) begin
         srst <= IDE_D_IN[2];
         nien <= IDE_D_IN[1];
      end
   end

   // task file and transfer FSM
   always_ff @(posedge CLKCPU) begin
      if (RESET || srst) begin
         state        <= S_IDLE;
         err          <= 1'b0;
         error_reg    <= ERR_DIAG_OK;
         seccnt       <= 9'd1;
         lba          <= '0;
         dev_hi       <= 4'hE;
         ptr          <= '0;
         be_cmd_valid <= 1'b0;
         be_cmd_write <= 1'b0;
         be_lba       <= '0;
         drain_prm    <= 1'b0;
         drain_done   <= 1'b0;
         irq_evt      <= 1'b0;
      end else begin
         irq_evt <= 1'b0;
         if (be_cmd_valid && BE_CMD_READY)
            be_cmd_valid <= 1'b0;
         if (abort) begin
            state        <= S_IDLE;
            err          <= 1'b1;
            error_reg    <= ERR_ABRT;
            ptr          <= '0;
            be_cmd_valid <= 1'b0;
            irq_evt      <= 1'b1;
         end else if (wr_cs0 && !busy) begin
            case (IDE_A)
               A_DATA: if (state == S_DRQ_WR) begin
                  ptr <= ptr + AW'(1);
                  if (last) begin
                     state        <= S_FLUSH;
                     ptr          <= '0;
                     drain_prm    <= 1'b0;
                     drain_done   <= 1'b0;
                     be_cmd_valid <= 1'b1;
                     be_cmd_write <= 1'b1;
                     be_lba       <= lba;
                  end
               end
               A_SECCNT: seccnt <= (IDE_D_IN[7:0] == 8'h00) ? 9'd256 : {1'b0, IDE_D_IN[7:0]};
               A_LBA0:   lba[7:0]   <= IDE_D_IN[7:0];
               A_LBA1:   lba[15:8]  <= IDE_D_IN[7:0];
               A_LBA2:   lba[23:16] <= IDE_D_IN[7:0];
               A_DEV: begin
                  dev_hi      <= IDE_D_IN[7:4];
                  lba[27:24]  <= IDE_D_IN[3:0];
               end
               A_CMD: begin
                  // only READ/WRITE reach here; everything else aborted above
                  err       <= 1'b0;
                  error_reg <= 8'h00;
                  ptr       <= '0;
                  if (IDE_D_IN[7:0] == CMD_READ) begin
                     state        <= S_FETCH;
                     be_cmd_valid <= 1'b1;
                     be_cmd_write <= 1'b0;
                     be_lba       <= lba;
                  end else begin
                     state        <= S_DRQ_WR;
                     be_cmd_valid <= 1'b0;
                  end
               end
               default: ;  // FEATURES: nothing implemented
            endcase
         end else begin
            case (state)
               S_FETCH: if (BE_FILL_VALID) begin
                  ptr <= ptr + AW'(1);
                  if (last) begin
                     ptr     <= '0;
                     state   <= S_DRQ_RD;
                     irq_evt <= 1'b1;
                  end
               end
               S_DRQ_RD: if (rd_ev && cs0 && IDE_A == A_DATA) begin
                  ptr <= ptr + AW'(1);
                  if (last) begin
                     ptr    <= '0;
                     lba    <= lba + 28'd1;
                     seccnt <= seccnt - 9'd1;
                     if (seccnt == 9'd1) begin
                        state   <= S_IDLE;
                        irq_evt <= 1'b1;
                     end else begin
                        state        <= S_FETCH;
                        be_cmd_valid <= 1'b1;
                        be_cmd_write <= 1'b0;
                        be_lba       <= lba + 28'd1;
                     end
                  end
               end
               S_FLUSH: begin
                  // one bubble after each accepted word lets the RAM read the next address
                  if (BE_DRAIN_VALID && BE_DRAIN_READY) begin
                     drain_prm <= 1'b0;
                     ptr       <= ptr + AW'(1);
                     if (last)
                        drain_done <= 1'b1;
                  end else begin
                     drain_prm <= 1'b1;
                  end
                  if (BE_DONE) begin
                     ptr        <= '0;
                     lba        <= lba + 28'd1;
                     seccnt     <= seccnt - 9'd1;
                     drain_prm  <= 1'b0;
                     drain_done <= 1'b0;
                     irq_evt    <= 1'b1;
                     state      <= (seccnt == 9'd1) ? S_IDLE : S_DRQ_WR;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // read mux for whatever register the host is addressing
   always_comb begin
      rd_mux = 16'h00FF;
      if (cs0) begin
         case (IDE_A)
            A_DATA:   rd_mux = (state == S_DRQ_RD) ? buf_rdata : 16'hFFFF;
            A_ERR:    rd_mux = {8'h00, error_reg};
            A_SECCNT: rd_mux = {8'h00, seccnt[7:0]};
            A_LBA0:   rd_mux = {8'h00, lba[7:0]};
            A_LBA1:   rd_mux = {8'h00, lba[15:8]};
            A_LBA2:   rd_mux = {8'h00, lba[23:16]};
            A_DEV:    rd_mux = {8'h00, dev_hi, lba[27:24]};
            default:  rd_mux = {8'h00, status};
         endcase
      end else if (cs1 && IDE_A == A_ALT) begin
         rd_mux = {8'h00, status};
      end
   end

   // bus drive; kept alive during SRST so the host can poll ALTSTATUS
   always_ff @(posedge CLKCPU) begin
      if (RESET) begin
         IDE_D_OUT <= '0;
         IDE_D_OE  <= 1'b0;
      end else begin
         IDE_D_OE <= (cs0 | cs1) & ~ior_s;
         if ((cs0 | cs1) && !ior_s)
            IDE_D_OUT <= rd_mux;
      end
   end

`ifdef ATA_INTRQ_EN
   logic intrq;

   // INTRQ: latched on protocol events unless masked, cleared by STATUS read or CMD write
   always_ff @(posedge CLKCPU) begin
      if (RESET || srst)
         intrq <= 1'b0;
      else if (irq_evt && !nien)
         intrq <= 1'b1;
      else if ((rd_ev || wr_ev) && cs0 && IDE_A == A_CMD)
         intrq <= 1'b0;
   end

   assign IDE_INTRQ = intrq;
`else
   logic intrq_unused;
   assign intrq_unused = nien ^ irq_evt;
   assign IDE_INTRQ    = 1'b0;
`endif

endmodule
